// File: rtl/uart_cmd_decoder.sv
// Single-byte command decoder between uart_rx and the memory-access engine.
// Define UART_CMD_TIMEOUT_EN to abandon WAIT_ARG after TIMEOUT_CYCLES idle cycles.
module uart_cmd_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd1000000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_count,
    input  logic        mem_done,
    input  logic [7:0]  mem_rdata,
    output logic        busy,
    output logic        cmd_err,
    output logic        cmd_drop
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ARG = 2'd1,
        ST_SEND_RSP = 2'd2,
        ST_MEM_BUSY = 2'd3
    } state_t;

    // Target index 0..3 selects an address byte, 4 selects the count register.
    localparam logic [2:0] TGT_COUNT = 3'd4;

    state_t      state_r;
    logic [2:0]  target_r;
    logic [7:0]  count_r;
    logic [31:0] addr_r;
    logic        tx_valid_r;
    logic [7:0]  tx_data_r;
    logic        mem_req_r;
    logic        mem_we_r;
    logic        busy_r;
    logic        cmd_err_r;
    logic        cmd_drop_r;
    logic        tmo_hit_s;

`ifdef UART_CMD_TIMEOUT_EN
    logic [31:0] tmo_cnt_r;

    // Idle-cycle counter for WAIT_ARG; parked at zero in every other state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tmo_cnt_r <= 32'd0;
        end else if (state_r != ST_WAIT_ARG || rx_valid) begin
            tmo_cnt_r <= 32'd0;
        end else begin
            tmo_cnt_r <= tmo_cnt_r + 32'd1;
        end
    end

    assign tmo_hit_s = (state_r == ST_WAIT_ARG) && !rx_valid &&
                       (tmo_cnt_r == 32'(TIMEOUT_CYCLES - 32'd1));
`else
    assign tmo_hit_s = 1'b0;
`endif

    // Command FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r    <= ST_IDLE;
            target_r   <= 3'd0;
            count_r    <= 8'd0;
            addr_r     <= 32'd0;
            tx_valid_r <= 1'b0;
            tx_data_r  <= 8'd0;
            mem_req_r  <= 1'b0;
            mem_we_r   <= 1'b0;
            busy_r     <= 1'b0;
            cmd_err_r  <= 1'b0;
            cmd_drop_r <= 1'b0;
        end else begin
            cmd_err_r  <= 1'b0;
            cmd_drop_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (rx_valid) begin
                        case (rx_data)
                            8'hA0: begin
                                target_r <= TGT_COUNT;
                                state_r  <= ST_WAIT_ARG;
                                busy_r   <= 1'b1;
                            end
                            8'hB0, 8'hB1, 8'hB2, 8'hB3: begin
                                target_r <= {1'b0, rx_data[1:0]};
                                state_r  <= ST_WAIT_ARG;
                                busy_r   <= 1'b1;
                            end
                            8'hA1: begin
                                tx_data_r  <= count_r;
                                tx_valid_r <= 1'b1;
                                state_r    <= ST_SEND_RSP;
                                busy_r     <= 1'b1;
                            end
                            8'hC0, 8'hC1, 8'hC2, 8'hC3: begin
                                tx_data_r  <= addr_r[{rx_data[1:0], 3'b000} +: 8];
                                tx_valid_r <= 1'b1;
                                state_r    <= ST_SEND_RSP;
                                busy_r     <= 1'b1;
                            end
                            8'hD0, 8'hD1: begin
                                mem_req_r <= 1'b1;
                                mem_we_r  <= ~rx_data[0];
                                state_r   <= ST_MEM_BUSY;
                                busy_r    <= 1'b1;
                            end
                            default: begin
                                cmd_err_r <= 1'b1;
                            end
                        endcase
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT_ARG: begin
                    // Any byte here is data, including values that look like opcodes.
                    if (rx_valid) begin
                        case (target_r)
                            3'd0:    addr_r[7:0]   <= rx_data;
                            3'd1:    addr_r[15:8]  <= rx_data;
                            3'd2:    addr_r[23:16] <= rx_data;
                            3'd3:    addr_r[31:24] <= rx_data;
                            default: count_r       <= rx_data;
                        endcase
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else if (tmo_hit_s) begin
                        cmd_err_r <= 1'b1;
                        state_r   <= ST_IDLE;
                        busy_r    <= 1'b0;
                    end else begin
                        state_r <= ST_WAIT_ARG;
                    end
                end
                ST_SEND_RSP: begin
                    cmd_drop_r <= rx_valid;
                    if (tx_ready) begin
                        tx_valid_r <= 1'b0;
                        state_r    <= ST_IDLE;
                        busy_r     <= 1'b0;
                    end else begin
                        state_r <= ST_SEND_RSP;
                    end
                end
                ST_MEM_BUSY: begin
                    cmd_drop_r <= rx_valid;
                    if (mem_done) begin
                        mem_req_r  <= 1'b0;
                        tx_valid_r <= 1'b1;
                        tx_data_r  <= mem_we_r ? 8'h00 : mem_rdata;
                        state_r    <= ST_SEND_RSP;
                    end else begin
                        state_r <= ST_MEM_BUSY;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    tx_valid_r <= 1'b0;
                    mem_req_r  <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign tx_valid  = tx_valid_r;
    assign tx_data   = tx_data_r;
    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = addr_r;
    assign mem_count = count_r;
    assign busy      = busy_r;
    assign cmd_err   = cmd_err_r;
    assign cmd_drop  = cmd_drop_r;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder: transaction-level model checked every cycle,
// plus hand-computed literal expectations. Timeout scenario runs when UART_CMD_TIMEOUT_EN is defined.
module tb_uart_cmd_decoder;

    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        resetn;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_count;
    logic        mem_done;
    logic [7:0]  mem_rdata;
    logic        busy;
    logic        cmd_err;
    logic        cmd_drop;

    always #5 clk = ~clk;

    uart_cmd_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .resetn(resetn), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_count(mem_count),
        .mem_done(mem_done), .mem_rdata(mem_rdata), .busy(busy),
        .cmd_err(cmd_err), .cmd_drop(cmd_drop)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Protocol model: pending response, pending memory op, or awaited argument.
    logic [7:0] m_addr [4];
    logic [7:0] m_count;
    int         m_target;
    int         m_wait;
    bit         m_rsp_pending;
    logic [7:0] m_rsp;
    bit         m_mem_pending;
    bit         m_mem_write;
    bit         m_err;
    bit         m_drop;
    bit         check_en = 1'b0;

    int n_drop_seen = 0;
    int n_err_seen  = 0;
    int n_hs_seen   = 0;
    int n_req_hi    = 0;
    int n_tv_hi     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_addr[i] = 8'h00;
        m_count = 8'h00; m_target = -1; m_wait = 0;
        m_rsp_pending = 1'b0; m_rsp = 8'h00;
        m_mem_pending = 1'b0; m_mem_write = 1'b0;
        m_err = 1'b0; m_drop = 1'b0;
    endtask

    task automatic model_step();
        m_err = 1'b0;
        m_drop = 1'b0;
        if (!resetn) begin
            model_reset();
        end else if (m_rsp_pending) begin
            if (rx_valid) m_drop = 1'b1;
            if (tx_ready) m_rsp_pending = 1'b0;
        end else if (m_mem_pending) begin
            if (rx_valid) m_drop = 1'b1;
            if (mem_done) begin
                m_mem_pending = 1'b0;
                m_rsp_pending = 1'b1;
                m_rsp = m_mem_write ? 8'h00 : mem_rdata;
            end
        end else if (m_target >= 0) begin
            if (rx_valid) begin
                if (m_target == 4) m_count = rx_data;
                else m_addr[m_target] = rx_data;
                m_target = -1;
            end
`ifdef UART_CMD_TIMEOUT_EN
            else begin
                m_wait++;
                if (m_wait == TMO) begin
                    m_target = -1;
                    m_err = 1'b1;
                end
            end
`endif
        end else if (rx_valid) begin
            if (rx_data == 8'hA0) begin
                m_target = 4; m_wait = 0;
            end else if (rx_data >= 8'hB0 && rx_data <= 8'hB3) begin
                m_target = int'(rx_data) - 'hB0; m_wait = 0;
            end else if (rx_data == 8'hA1) begin
                m_rsp_pending = 1'b1; m_rsp = m_count;
            end else if (rx_data >= 8'hC0 && rx_data <= 8'hC3) begin
                m_rsp_pending = 1'b1; m_rsp = m_addr[int'(rx_data) - 'hC0];
            end else if (rx_data == 8'hD0 || rx_data == 8'hD1) begin
                m_mem_pending = 1'b1; m_mem_write = (rx_data == 8'hD0);
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (check_en) begin
            check("tx_valid", {31'd0, tx_valid}, {31'd0, m_rsp_pending});
            if (m_rsp_pending) check("tx_data", {24'd0, tx_data}, {24'd0, m_rsp});
            check("mem_req", {31'd0, mem_req}, {31'd0, m_mem_pending});
            if (m_mem_pending) check("mem_we", {31'd0, mem_we}, {31'd0, m_mem_write});
            check("mem_addr", mem_addr, {m_addr[3], m_addr[2], m_addr[1], m_addr[0]});
            check("mem_count", {24'd0, mem_count}, {24'd0, m_count});
            check("busy", {31'd0, busy},
                  {31'd0, m_rsp_pending | m_mem_pending | (m_target >= 0)});
            check("cmd_err", {31'd0, cmd_err}, {31'd0, m_err});
            check("cmd_drop", {31'd0, cmd_drop}, {31'd0, m_drop});
            if (cmd_drop) n_drop_seen++;
            if (cmd_err) n_err_seen++;
            if (tx_valid && tx_ready) n_hs_seen++;
            if (mem_req) n_req_hi++;
            if (tx_valid) n_tv_hi++;
        end
    end

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        cycle();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    initial begin
        resetn = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
        mem_done = 1'b0; mem_rdata = 8'h00;
        model_reset();
        check_en = 1'b1;
        repeat (3) cycle();
        resetn = 1'b1;
        check("rst_addr", mem_addr, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'h0);
        check("rst_tx_data", {24'd0, tx_data}, 32'h0);

        // Reads of all-zero registers, back to back.
        tx_ready = 1'b1;
        foreach (m_addr[i]) ;
        send_byte(8'hA1); check("rsp_a1_zero", {23'd0, tx_valid, tx_data}, 32'h100); cycle();
        send_byte(8'hC0); check("rsp_c0_zero", {23'd0, tx_valid, tx_data}, 32'h100); cycle();
        send_byte(8'hC1); cycle();
        send_byte(8'hC2); cycle();
        send_byte(8'hC3); cycle();
        check("five_handshakes", n_hs_seen, 32'd5);
        check("no_drops", n_drop_seen, 32'd0);

        // Register writes.
        send_byte(8'hA0); send_byte(8'h34);
        send_byte(8'hB0); send_byte(8'hAB);
        send_byte(8'hB1); send_byte(8'hCD);
        send_byte(8'hB2); send_byte(8'hEF);
        send_byte(8'hB3); send_byte(8'hCD);
        check("count_34", {24'd0, mem_count}, 32'h34);
        check("addr_cdefcdab", mem_addr, 32'hCDEFCDAB);
        send_byte(8'hA1); check("rsp_count", {24'd0, tx_data}, 32'h34); cycle();
        send_byte(8'hC3); check("rsp_addr3", {24'd0, tx_data}, 32'hCD); cycle();

        // Memory read with a dropped byte while busy.
        tx_ready = 1'b0;
        mem_done = 1'b1;
        cycle();
        mem_done = 1'b0;
        n_req_hi = 0;
        send_byte(8'hD1);
        check("rd_we0", {30'd0, mem_req, mem_we}, 32'h2);
        cycle(); cycle();
        send_byte(8'h11);
        check("drop_in_mem", {31'd0, cmd_drop}, 32'h1);
        cycle(); cycle();
        mem_done = 1'b1; mem_rdata = 8'h5A;
        cycle();
        mem_done = 1'b0; mem_rdata = 8'h00;
        check("rd_data", {22'd0, mem_req, tx_valid, tx_data}, 32'h15A);
        check("req_6_cycles", n_req_hi, 32'd6);
        tx_ready = 1'b1; cycle(); tx_ready = 1'b0;

        // Memory write with a stalled transmitter.
        send_byte(8'hD0);
        check("wr_we1", {30'd0, mem_req, mem_we}, 32'h3);
        cycle(); cycle();
        mem_done = 1'b1; cycle(); mem_done = 1'b0;
        n_tv_hi = 0;
        repeat (10) cycle();
        check("wr_ack_held", {23'd0, tx_valid, tx_data}, 32'h100);
        tx_ready = 1'b1; cycle(); tx_ready = 1'b0;
        check("ack_tv_cycles", n_tv_hi, 32'd11);
        check("ack_handed_off", {31'd0, tx_valid}, 32'h0);

        // Unknown opcode, then an opcode-valued argument.
        n_err_seen = 0;
        send_byte(8'h7E);
        check("err_pulse", {30'd0, cmd_err, busy}, 32'h2);
        cycle();
        check("err_one_pulse", n_err_seen, 32'd1);
        send_byte(8'hA0); send_byte(8'hA1);
        check("count_a1", {24'd0, mem_count}, 32'hA1);

        // Extreme byte values; no carry between address bytes.
        send_byte(8'hB3); send_byte(8'hFF);
        send_byte(8'hB0); send_byte(8'hFF);
        send_byte(8'hB1); send_byte(8'h00);
        check("addr_no_carry", mem_addr, 32'hFFEF00FF);

        // Byte arriving on the handshake cycle is dropped; next opcode accepted right after.
        send_byte(8'hA1);
        cycle();
        tx_ready = 1'b1;
        send_byte(8'hC0);
        tx_ready = 1'b0;
        check("drop_on_hs", {30'd0, cmd_drop, tx_valid}, 32'h2);
        send_byte(8'hC2);
        check("b2b_rsp", {23'd0, tx_valid, tx_data}, 32'h1EF);
        tx_ready = 1'b1; cycle(); tx_ready = 1'b0;

        // Asynchronous reset in the middle of a memory request.
        send_byte(8'hD1);
        cycle();
        resetn = 1'b0;
        model_reset();
        #2;
        check("async_rst_req", {30'd0, mem_req, busy}, 32'h0);
        cycle(); cycle();
        resetn = 1'b1;
        mem_done = 1'b1; cycle(); mem_done = 1'b0;
        cycle();
        check("no_req_after_rst", {31'd0, mem_req}, 32'h0);
        check("addr_after_rst", mem_addr, 32'h0);

`ifdef UART_CMD_TIMEOUT_EN
        n_err_seen = 0;
        send_byte(8'hB2);
        repeat (TMO - 1) cycle();
        check("tmo_not_yet", {30'd0, cmd_err, busy}, 32'h1);
        cycle();
        check("tmo_err", {30'd0, cmd_err, busy}, 32'h2);
        send_byte(8'h55);
        check("tmo_55_opcode", {31'd0, cmd_err}, 32'h1);
        check("tmo_addr_kept", mem_addr, 32'h0);
        check("tmo_err_count", n_err_seen, 32'd2);
`else
        send_byte(8'hB2);
        repeat (150) cycle();
        check("wait_forever", {30'd0, cmd_err, busy}, 32'h1);
        send_byte(8'h12);
        check("late_arg", mem_addr, 32'h00120000);
`endif

        cycle();
        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
